// File: rtl/pa_fpu.sv
// Shared types, register map and status bit positions for the add/sub FPU.
package pa_fpu;

    typedef enum logic [3:0] {
        op_add = 4'd0,
        op_sub = 4'd1,
        op_mul = 4'd2,
        op_div = 4'd3
    } e_fpu_operation;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } e_fpu_state;

    localparam int ADDR_OPA  = 'h00;
    localparam int ADDR_OPB  = 'h04;
    localparam int ADDR_CMD  = 'h08;
    localparam int ADDR_STAT = 'h09;
    localparam int ADDR_RES  = 'h0C;

    localparam int STAT_BUSY = 0;
    localparam int STAT_END  = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_UNF  = 3;
    localparam int STAT_INV  = 4;
    localparam int STAT_INX  = 5;
    localparam int STAT_REJ  = 6;

endpackage

// File: rtl/fpu_align_shift.sv
// Right shifter for operand alignment; bits shifted out are OR-ed into sticky.
module fpu_align_shift #(
    parameter int WIDTH = 27,
    parameter int SH_W  = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SH_W-1:0]  shamt,
    output logic [WIDTH-1:0] dout,
    output logic             sticky
);
    logic [WIDTH-1:0] mask;

    always_comb begin
        mask = '0;
        if (int'(shamt) >= WIDTH) begin
            dout   = '0;
            sticky = |din;
        end else begin
            dout   = din >> shamt;
            mask   = ~({WIDTH{1'b1}} << shamt);
            sticky = |(din & mask);
        end
    end

endmodule

// File: rtl/fpu_addsub_seq.sv
// Multi-cycle float add/subtract behind the 8-bit CPU bus; cmd_end flags completion.
module fpu_addsub_seq
    import pa_fpu::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [7:0]        databus_in,
    output logic [7:0]        databus_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic              end_ack,
    output logic              cmd_end,
    output logic              busy
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int NB = W / 8;
    localparam int AW = MAN_W + 4;   // hidden, fraction, G, R, S
    localparam int DW = MAN_W + 5;   // plus carry
    localparam int XW = EXP_W + 2;   // MSB acts as sign during normalisation
    localparam logic [XW-1:0]    EXP_INF  = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    e_fpu_state     state;
    e_fpu_operation operation;
    logic [W-1:0]   operand_a, operand_b, result;
    logic           f_ovf, f_unf, f_inv, f_inx, f_rej;
    logic           res_sign, eff_sub, zero_sign;
    logic [XW-1:0]  exp_r;
    logic [AW-1:0]  big_m, small_m;
    logic [DW-1:0]  sum_m;

    // ---- operand unpack and swap
    logic             sa, sb, za, zb, swap, s_big, s_small;
    logic [EXP_W-1:0] ea, eb, e_big, e_small, shamt;
    logic [MAN_W-1:0] fa, fb;
    logic [W-2:0]     mag_a, mag_b;
    logic [AW-1:0]    ma, mb, m_big, m_small, small_sh;
    logic             small_st, a_nan, b_nan, a_inf, b_inf, special, special_inv;
    logic [W-1:0]     special_res;

    assign sa    = operand_a[W-1];
    assign ea    = operand_a[W-2 -: EXP_W];
    assign fa    = operand_a[MAN_W-1:0];
    assign sb    = operand_b[W-1] ^ (operation == op_sub);
    assign eb    = operand_b[W-2 -: EXP_W];
    assign fb    = operand_b[MAN_W-1:0];
    assign za    = (ea == '0);
    assign zb    = (eb == '0);
    assign mag_a = za ? '0 : operand_a[W-2:0];
    assign mag_b = zb ? '0 : operand_b[W-2:0];
    assign ma    = za ? '0 : {1'b1, fa, 3'b000};
    assign mb    = zb ? '0 : {1'b1, fb, 3'b000};
    assign swap  = mag_b > mag_a;

    assign e_big   = swap ? eb : ea;
    assign e_small = swap ? ea : eb;
    assign m_big   = swap ? mb : ma;
    assign m_small = swap ? ma : mb;
    assign s_big   = swap ? sb : sa;
    assign s_small = swap ? sa : sb;
    assign shamt   = e_big - e_small;

    fpu_align_shift #(.WIDTH(AW), .SH_W(EXP_W)) u_align_shift (
        .din    (m_small),
        .shamt  (shamt),
        .dout   (small_sh),
        .sticky (small_st)
    );

    assign a_nan       = (ea == EXP_ONES) && (fa != '0);
    assign b_nan       = (eb == EXP_ONES) && (fb != '0);
    assign a_inf       = (ea == EXP_ONES) && (fa == '0);
    assign b_inf       = (eb == EXP_ONES) && (fb == '0);
    assign special     = a_nan | b_nan | a_inf | b_inf;
    assign special_inv = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
    assign special_res = special_inv ? QNAN
                       : a_inf       ? {sa, EXP_ONES, {MAN_W{1'b0}}}
                       :               {sb, EXP_ONES, {MAN_W{1'b0}}};

    // ---- round to nearest even on the normalised mantissa
    logic             rg, rr, rs, rnd_up, rnd_inx, rnd_ovf, rnd_unf;
    logic [MAN_W+1:0] rnd;
    logic [XW-1:0]    rnd_exp;
    logic [MAN_W-1:0] rnd_frac;

    assign rg       = sum_m[2];
    assign rr       = sum_m[1];
    assign rs       = sum_m[0];
    assign rnd_up   = rg & (rr | rs | sum_m[3]);
    assign rnd_inx  = rg | rr | rs;
    assign rnd      = {1'b0, sum_m[DW-2:3]} + (MAN_W+2)'(rnd_up);
    assign rnd_exp  = rnd[MAN_W+1] ? exp_r + XW'(1) : exp_r;
    assign rnd_frac = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    assign rnd_ovf  = !rnd_exp[XW-1] && (rnd_exp >= EXP_INF);
    assign rnd_unf  = rnd_exp[XW-1] || (rnd_exp == '0);

    // ---- bus decode
    logic       wr_en, rd_en, hit_a, hit_b, hit_cmd;
    logic [7:0] rd_data;

    assign wr_en   = !cs && !wr;
    assign rd_en   = !cs && !rd;
    assign hit_cmd = (addr == ADDR_W'(ADDR_CMD));

    always_comb begin
        hit_a   = 1'b0;
        hit_b   = 1'b0;
        rd_data = '0;
        for (int i = 0; i < 4; i++) begin
            if (addr == ADDR_W'(ADDR_OPA + i)) hit_a = 1'b1;
            if (addr == ADDR_W'(ADDR_OPB + i)) hit_b = 1'b1;
        end
        for (int i = 0; i < NB; i++) begin
            if (addr == ADDR_W'(ADDR_OPA + i)) rd_data = operand_a[8*i +: 8];
            if (addr == ADDR_W'(ADDR_OPB + i)) rd_data = operand_b[8*i +: 8];
            if (addr == ADDR_W'(ADDR_RES + i)) rd_data = result[8*i +: 8];
        end
        if (hit_cmd) rd_data = {4'b0000, operation};
        if (addr == ADDR_W'(ADDR_STAT)) begin
            rd_data[STAT_BUSY] = busy;
            rd_data[STAT_END]  = cmd_end;
            rd_data[STAT_OVF]  = f_ovf;
            rd_data[STAT_UNF]  = f_unf;
            rd_data[STAT_INV]  = f_inv;
            rd_data[STAT_INX]  = f_inx;
            rd_data[STAT_REJ]  = f_rej;
        end
    end

    assign databus_out = rd_en ? rd_data : 8'bzzzzzzzz;

    always_ff @(posedge clk) begin
        if (arst) begin
            state     <= S_IDLE;
            operation <= op_add;
            operand_a <= '0;
            operand_b <= '0;
            result    <= '0;
            {f_ovf, f_unf, f_inv, f_inx, f_rej} <= '0;
            busy      <= 1'b0;
            cmd_end   <= 1'b0;
            res_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            zero_sign <= 1'b0;
            exp_r     <= '0;
            big_m     <= '0;
            small_m   <= '0;
            sum_m     <= '0;
        end else begin
            if (end_ack) cmd_end <= 1'b0;

            case (state)
                S_IDLE: ;
                S_ALIGN: begin
                    exp_r     <= XW'(e_big);
                    res_sign  <= s_big;
                    eff_sub   <= s_big ^ s_small;
                    zero_sign <= sa & sb;
                    big_m     <= m_big;
                    small_m   <= small_sh | AW'(small_st);
                    state     <= S_ADD;
                    if (special) begin
                        result  <= special_res;
                        f_inv   <= special_inv;
                        busy    <= 1'b0;
                        cmd_end <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                S_ADD: begin
                    sum_m <= eff_sub ? {1'b0, big_m} - {1'b0, small_m}
                                     : {1'b0, big_m} + {1'b0, small_m};
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (sum_m == '0) begin
                        result  <= {zero_sign, {(W-1){1'b0}}};
                        busy    <= 1'b0;
                        cmd_end <= 1'b1;
                        state   <= S_DONE;
                    end else if (sum_m[DW-1]) begin
                        sum_m <= {1'b0, sum_m[DW-1:2], sum_m[1] | sum_m[0]};
                        exp_r <= exp_r + XW'(1);
                        state <= S_ROUND;
                    end else if (sum_m[DW-2]) begin
                        state <= S_ROUND;
                    end else begin
                        sum_m <= sum_m << 1;
                        exp_r <= exp_r - XW'(1);
                    end
                end
                S_ROUND: begin
                    f_inx <= rnd_inx;
                    if (rnd_ovf) begin
                        result <= {res_sign, EXP_ONES, {MAN_W{1'b0}}};
                        f_ovf  <= 1'b1;
                        f_inx  <= 1'b1;
                    end else if (rnd_unf) begin
                        result <= {res_sign, {(W-1){1'b0}}};
                        f_unf  <= 1'b1;
                        f_inx  <= 1'b1;
                    end else begin
                        result <= {res_sign, rnd_exp[EXP_W-1:0], rnd_frac};
                    end
                    busy    <= 1'b0;
                    cmd_end <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // Bus writes come last so a new command issued in DONE overrides the return to IDLE.
            if (wr_en) begin
                if (busy) begin
                    if (hit_a || hit_b || hit_cmd) f_rej <= 1'b1;
                end else begin
                    for (int i = 0; i < NB; i++) begin
                        if (addr == ADDR_W'(ADDR_OPA + i)) operand_a[8*i +: 8] <= databus_in;
                        if (addr == ADDR_W'(ADDR_OPB + i)) operand_b[8*i +: 8] <= databus_in;
                    end
                    if (hit_cmd) begin
                        if (databus_in[3:0] == op_add || databus_in[3:0] == op_sub) begin
                            operation <= e_fpu_operation'(databus_in[3:0]);
                            {f_ovf, f_unf, f_inv, f_inx, f_rej} <= '0;
                            cmd_end   <= 1'b0;
                            busy      <= 1'b1;
                            state     <= S_ALIGN;
                        end else begin
                            f_inv   <= 1'b1;
                            cmd_end <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule
